sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 13 +
 rtl/sram_arb_rr.sv | 18 +
 rtl/sram_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared widths and FSM state type for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned ADR  = 8;
  localparam int unsigned DATA = 8;
  localparam int unsigned NREQ = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Round-robin pick between two requesters: eligible mask + last winner -> one-hot grant.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic [NREQ-1:0] eligible,
  input  logic            last,
  output logic [NREQ-1:0] grant_c
);

  // A lone eligible requester wins outright; on contention the one not granted last wins.
  always_comb begin
    grant_c = eligible;
    if (&eligible) begin
      grant_c = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: one command per ISSUE cycle, round-robin on contention,
// read data returned two cycles after the grant.
module sram_arbiter #(
  parameter int unsigned ADR  = sram_arb_pkg::ADR,
  parameter int unsigned DATA = sram_arb_pkg::DATA
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [sram_arb_pkg::NREQ-1:0]      req,
  input  logic [sram_arb_pkg::NREQ-1:0]      we,
  input  logic [sram_arb_pkg::NREQ*ADR-1:0]  addr,
  input  logic [sram_arb_pkg::NREQ*DATA-1:0] wdata,
  output logic [sram_arb_pkg::NREQ-1:0]      gnt,
  output logic [sram_arb_pkg::NREQ-1:0]      rvalid,
  output logic [DATA-1:0]                    rdata,
  output logic                               mem_cs,
  output logic                               mem_we,
  output logic                               mem_rd,
  output logic [ADR-1:0]                     mem_addr,
  output logic [DATA-1:0]                    mem_din,
  input  logic [DATA-1:0]                    mem_dout,
  output logic                               busy
);

  import sram_arb_pkg::*;

  state_t            state, state_nx;
  logic              last, last_nx;
  logic [NREQ-1:0]   eligible, pick_c;
  logic [NREQ-1:0]   gnt_nx, rvalid_nx;
  logic [NREQ-1:0]   rd_pend, rd_pend_nx;
  logic [DATA-1:0]   rdata_nx, din_nx;
  logic [ADR-1:0]    addr_nx;
  logic              cs_nx, we_nx, rd_nx, busy_nx;
  logic              k;

  // The requester on the bus this cycle still holds req for the same command.
  assign eligible = req & ~((state == ISSUE) ? gnt : '0);

  sram_arb_rr u_rr (
    .eligible (eligible),
    .last     (last),
    .grant_c  (pick_c)
  );

  always_comb begin
    state_nx   = IDLE;
    gnt_nx     = '0;
    cs_nx      = 1'b0;
    we_nx      = 1'b0;
    rd_nx      = 1'b0;
    addr_nx    = mem_addr;
    din_nx     = mem_din;
    last_nx    = last;
    k          = pick_c[1];
    // rd_pend marks the requester whose read was on the bus last cycle.
    rd_pend_nx = (mem_cs && mem_rd) ? gnt : '0;
    rvalid_nx  = rd_pend;
    rdata_nx   = (|rd_pend) ? mem_dout : rdata;
    if (|pick_c) begin
      state_nx = ISSUE;
      gnt_nx   = pick_c;
      cs_nx    = 1'b1;
      we_nx    = we[k];
      rd_nx    = ~we[k];
      addr_nx  = k ? addr[ADR +: ADR] : addr[0 +: ADR];
      din_nx   = k ? wdata[DATA +: DATA] : wdata[0 +: DATA];
      last_nx  = k;
    end
    busy_nx = (state_nx == ISSUE) | (|rd_pend_nx);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt      <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      rd_pend  <= '0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      gnt      <= gnt_nx;
      rvalid   <= rvalid_nx;
      rdata    <= rdata_nx;
      rd_pend  <= rd_pend_nx;
      mem_cs   <= cs_nx;
      mem_we   <= we_nx;
      mem_rd   <= rd_nx;
      mem_addr <= addr_nx;
      mem_din  <= din_nx;
      busy     <= busy_nx;
    end
  end

endmodule
